// File: rtl/score_glyph_reader.sv
// rtl/score_glyph_reader.sv - score BCD conversion and glyph RAM read pipeline
// Double-dabble score converter plus a 2-stage pixel-to-glyph lookup against a 1-cycle sprite RAM.
module score_glyph_reader #(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    ADDR_WIDTH  = 16,
    parameter int                    GLYPH_W     = 16,
    parameter int                    GLYPH_H     = 24,
    parameter int                    NUM_DIGITS  = 4,
    parameter logic [9:0]            ORIGIN_X    = 10'd8,
    parameter logic [9:0]            ORIGIN_Y    = 10'd8,
    parameter logic [DATA_WIDTH-1:0] TRANSPARENT = 8'h00
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [13:0]           score_i,
    input  logic                  score_load,
    output logic                  busy,
    input  logic [9:0]            pix_x,
    input  logic [9:0]            pix_y,
    input  logic                  pix_valid,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    output logic                  out_valid,
    output logic                  out_hit,
    output logic [DATA_WIDTH-1:0] out_data
);

    localparam int         BW        = 4 * NUM_DIGITS;
    localparam logic [13:0] SCORE_MAX = 14'(10 ** NUM_DIGITS - 1);
    localparam logic [10:0] X_END     = 11'(ORIGIN_X + NUM_DIGITS * GLYPH_W);
    localparam logic [10:0] Y_END     = 11'(ORIGIN_Y + GLYPH_H);

    typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE} state_t;

    state_t          r_state;
    logic [13:0]     r_bin;
    logic [BW-1:0]   r_bcd;
    logic [3:0]      r_cnt;
    logic [BW-1:0]   r_disp;
    logic [BW-1:0]   w_bcd_adj;

    logic            r_valid_d1;
    logic            r_valid_d2;
    logic            r_en_d2;

    logic [9:0]      w_dx;
    logic [9:0]      w_dy;
    logic [9:0]      w_d;
    logic [9:0]      w_gx;
    logic            w_in_box;
    logic [3:0]      w_sel;
    logic            w_sel_blank;
    logic            w_lead;
    logic            w_en;
    logic [ADDR_WIDTH-1:0] w_addr;

    always_comb begin
        w_bcd_adj = r_bcd;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (r_bcd[k*4 +: 4] >= 4'd5)
                w_bcd_adj[k*4 +: 4] = r_bcd[k*4 +: 4] + 4'd3;
        end
    end

    // Display regs only move in DONE, so the pixel path never sees a half-converted value.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_bin   <= '0;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_disp  <= '0;
            busy    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (score_load) begin
                        r_bin   <= (score_i > SCORE_MAX) ? SCORE_MAX : score_i;
                        r_bcd   <= '0;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= S_CONV;
                    end
                end
                S_CONV: begin
                    {r_bcd, r_bin} <= {w_bcd_adj, r_bin} << 1;
                    r_cnt          <= r_cnt + 4'd1;
                    if (r_cnt == 4'd13)
                        r_state <= S_DONE;
                end
                S_DONE: begin
                    r_disp  <= r_bcd;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_dx     = pix_x - ORIGIN_X;
    assign w_dy     = pix_y - ORIGIN_Y;
    assign w_in_box = pix_valid
                    && (pix_x >= ORIGIN_X) && ({1'b0, pix_x} < X_END)
                    && (pix_y >= ORIGIN_Y) && ({1'b0, pix_y} < Y_END);

    // Digit 0 is the most significant nibble; leading zeros blank except the last digit.
    always_comb begin
        w_d         = 10'(32'(w_dx) / GLYPH_W);
        w_gx        = 10'(32'(w_dx) % GLYPH_W);
        w_sel       = '0;
        w_sel_blank = 1'b0;
        w_lead      = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            w_lead = w_lead && (r_disp[(NUM_DIGITS-1-k)*4 +: 4] == 4'd0);
            if (w_d == 10'(k)) begin
                w_sel       = r_disp[(NUM_DIGITS-1-k)*4 +: 4];
                w_sel_blank = w_lead && (k != NUM_DIGITS - 1);
            end
        end
        w_en   = w_in_box && !w_sel_blank;
        w_addr = ADDR_WIDTH'(32'(w_sel) * GLYPH_W * GLYPH_H + 32'(w_dy) * GLYPH_W + 32'(w_gx));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_en     <= 1'b0;
            mem_addr   <= '0;
            r_valid_d1 <= 1'b0;
            r_valid_d2 <= 1'b0;
            r_en_d2    <= 1'b0;
        end else begin
            mem_en     <= w_en;
            if (w_en)
                mem_addr <= w_addr;
            r_valid_d1 <= pix_valid;
            r_valid_d2 <= r_valid_d1;
            r_en_d2    <= mem_en;
        end
    end

    // RAM data arrives in cycle 2, already registered by the RAM itself.
    assign mem_we    = 1'b0;
    assign out_valid = r_valid_d2;
    assign out_hit   = r_en_d2 && (mem_data_i != TRANSPARENT);
    assign out_data  = out_hit ? mem_data_i : '0;

endmodule
